reco_dot_acc: RTL

Streaming dot-product accumulator for the Axiline recommendation training datapath. It sits directly upstream of the recommendation combinational stage. It consumes one user/item feature pair per beat and accumulates the products over a fixed-length vector. It then presents the finished prediction as `data_out`, which the combinational stage scales by rate, bias and mu.

---
 rtl/reco_pkg.sv | 13 +
 rtl/reco_dot_acc_if.sv | 15 +
 rtl/reco_mac.sv | 27 ++
 rtl/reco_dot_acc.sv | 56 +++++
 4 files changed

// File: rtl/reco_pkg.sv
// reco_pkg: shared state enum, default widths and saturation limits for the reco datapath
package reco_pkg;
  localparam int BITWIDTH = 32;
  localparam int INPUT_BITWIDTH = 16;
  localparam int VEC_LEN = 8;
  typedef enum logic {ACC, HOLD} state_t;
  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction
  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction
endpackage

// File: rtl/reco_dot_acc_if.sv
// reco_dot_acc_if: feature-pair input stream and result output stream
interface reco_dot_acc_if #(
  parameter int bitwidth = 32,
  parameter int inputBitwidth = 16
) ();
  logic [inputBitwidth-1:0] in_a;
  logic [inputBitwidth-1:0] in_b;
  logic in_valid;
  logic in_ready;
  logic [bitwidth-1:0] data_out;
  logic out_valid;
  logic out_ready;
  modport master (output in_a, in_b, in_valid, out_ready, input in_ready, data_out, out_valid);
  modport slave (input in_a, in_b, in_valid, out_ready, output in_ready, data_out, out_valid);
endinterface

// File: rtl/reco_mac.sv
// reco_mac: signed multiply-add; saturating accumulate when RECO_SAT_EN is defined, wrapping otherwise
module reco_mac
  import reco_pkg::*;
#(
  parameter int bitwidth = BITWIDTH,
  parameter int inputBitwidth = INPUT_BITWIDTH
) (
  input  logic signed [inputBitwidth-1:0] a,
  input  logic signed [inputBitwidth-1:0] b,
  input  logic signed [bitwidth-1:0] acc_in,
  output logic signed [bitwidth-1:0] acc_out
);
  logic signed [2*inputBitwidth-1:0] prod;
  logic signed [bitwidth-1:0] term;
  assign prod = a * b;
  assign term = bitwidth'(prod);
`ifdef RECO_SAT_EN
  logic signed [bitwidth:0] sum;
  assign sum = acc_in + term;
  // differing top two bits of the one-bit-wider sum mean overflow
  assign acc_out = (sum[bitwidth] != sum[bitwidth-1]) ?
                   (sum[bitwidth] ? bitwidth'(sat_min(bitwidth)) : bitwidth'(sat_max(bitwidth))) :
                   sum[bitwidth-1:0];
`else
  assign acc_out = acc_in + term;
`endif
endmodule

// File: rtl/reco_dot_acc.sv
// reco_dot_acc: streaming dot-product accumulator over vec_len feature pairs (RECO_SAT_EN selects saturation)
module reco_dot_acc
  import reco_pkg::*;
#(
  parameter int bitwidth = BITWIDTH,
  parameter int inputBitwidth = INPUT_BITWIDTH,
  parameter int vec_len = VEC_LEN
) (
  input logic clk,
  input logic rst,
  reco_dot_acc_if.slave bus
);
  localparam int cw = $clog2(vec_len);
  state_t state;
  logic signed [bitwidth-1:0] acc, acc_next;
  logic [cw-1:0] cnt;
  logic rdy, vld;
  logic [bitwidth-1:0] dout;
  reco_mac #(.bitwidth(bitwidth), .inputBitwidth(inputBitwidth)) u_mac (
    .a(bus.in_a),
    .b(bus.in_b),
    .acc_in(acc),
    .acc_out(acc_next)
  );
  assign bus.in_ready = rdy;
  assign bus.out_valid = vld;
  assign bus.data_out = dout;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACC;
      acc <= '0;
      cnt <= '0;
      dout <= '0;
      vld <= 1'b0;
      rdy <= 1'b1;
    end else if (state == ACC) begin
      if (bus.in_valid) begin
        acc <= acc_next;
        if (cnt == cw'(vec_len - 1)) begin
          state <= HOLD;
          cnt <= '0;
          dout <= acc_next;
          vld <= 1'b1;
          rdy <= 1'b0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end else if (bus.out_ready) begin
      state <= ACC;
      acc <= '0;
      vld <= 1'b0;
      rdy <= 1'b1;
    end
  end
endmodule
